// File: rtl/popcount_accum.sv
// ============================================================================
// Module      : popcount_accum
// Description : Streaming set-bit (or clear-bit) accumulator over a framed
//               valid/ready packet, with saturating or wrapping counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_accum #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 13,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              count_zeros,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  out,
    output logic              overflow
);

    localparam int PC_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   acc;
    logic               ovf;
    logic               mode;
    logic [DATA_W-1:0]  word;
    logic [PC_W-1:0]    pc;
    logic [CNT_W:0]     sum;
    logic [CNT_W-1:0]   acc_next;
    logic               beat;

    always_comb begin
        word = mode ? ~in_data : in_data;
        pc   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pc = pc + PC_W'(word[i]);
        end
    end

    // Extra carry bit flags overflow; saturation pins acc at all-ones.
    assign sum      = {1'b0, acc} + (CNT_W + 1)'(pc);
    assign acc_next = (sum[CNT_W] && SAT) ? '1 : sum[CNT_W-1:0];
    assign beat     = in_valid && in_ready;

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (beat && in_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            ovf  <= 1'b0;
            mode <= 1'b0;
        end else if (state == IDLE && start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            mode <= count_zeros;
        end else if (beat) begin
            acc  <= acc_next;
            ovf  <= ovf | sum[CNT_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                out      <= acc;
                overflow <= ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/popcount_accum.md
# popcount_accum

Streaming set-bit accumulator for the mining datapath. It counts the 1s (or 0s) in every word of a packet and sums them into a parametrised-width counter. The packet arrives on a valid/ready stream framed by `start` and `in_last`. When the packet ends it presents the total with a one-cycle `done` pulse. It supersedes the fixed 8-bit, state-driven bit adder: the internal FSM replaces the external state input, and width, counter size, overflow policy and count mode are configurable.

## Interface
- `DATA_W`, 8: input word width in bits; must be ≥1.
- `CNT_W`, 13: accumulator/result width; must be ≥ clog2(DATA_W+1).
- `SAT`, 1: overflow policy. 1 = saturate at 2^CNT_W−1; 0 = wrap modulo 2^CNT_W.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a packet; honoured only in IDLE.
- `count_zeros`  in  1  mode, sampled with `start`. 0 = count 1s, 1 = count 0s.
- `in_valid`  in  1  `in_data` valid.
- `in_data`  in  DATA_W  input word.
- `in_last`  in  1  qualifies the final word of the packet; meaningful only with `in_valid`.
- `in_ready`  out  1  block accepts a word; combinational, high exactly in ACCUM.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  single-cycle result strobe, registered.
- `out`  out  CNT_W  last completed result, registered, held until the next completion.
- `overflow`  out  1  last completed result overflowed, registered, held with `out`.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=0; input beats are not accepted.
  - When `start`=1, clear `acc` and the internal sticky `ovf`, latch `count_zeros` into `mode`, and go to ACCUM.
- ACCUM:
  - A beat is accepted when `in_valid`&&`in_ready`.
  - Each accepted beat adds pc = popcount(mode ? ~in_data : in_data) to `acc`.
  - An accepted beat with `in_last`=1 moves to DONE; that word is included in the sum.
  - `start` is ignored. `in_valid`=0 cycles are idle gaps with no effect.
- DONE (one cycle):
  - Register `out`<=`acc`, `overflow`<=`ovf`, `done`<=1, then go to IDLE.
  - `in_ready`=0.
- Arithmetic:
  - pc is clog2(DATA_W+1) bits wide, zero-extended.
  - The sum is computed CNT_W+1 bits wide. If it exceeds 2^CNT_W−1, set `ovf`=1 (sticky for the packet).
  - SAT=1: `acc` becomes all-ones and stays there.
  - SAT=0: `acc` takes the low CNT_W bits.
- Empty packet is not possible; a packet contains at least its `in_last` word.
- `done` is deasserted on every cycle except the one following DONE.

## Timing
- Reset (`reset`=0, async) forces: state IDLE, `acc`=0, `ovf`=0, `mode`=0, `out`=0, `overflow`=0, `done`=0, `in_ready`=0, `busy`=0.
- Reset asserted mid-packet aborts it; no `done` is produced, and `out` and `overflow` are cleared.
- Release is synchronised by the system; the first edge after release samples IDLE.
- `start` sampled at edge S → ACCUM from S; `in_ready`=1 in the following cycle, so the first beat can be accepted at edge S+1.
- Throughput: one word per cycle, with no bubbles while in ACCUM.
- Last beat accepted at edge N → state DONE after N; `out`, `overflow` and `done` update at edge N+1. `done` is high for exactly cycle N+1..N+2.
- Latency from last beat to `done` is therefore 1 cycle after the accepting edge.
- Back-to-back packets:
  - `start` may be asserted in the cycle where `done`=1, since the state is IDLE then. It is accepted.
  - Minimum gap between packets is 2 cycles (DONE plus IDLE).
- `start` asserted together with `in_valid` in IDLE: only `start` takes effect, and that beat is not consumed.

## Test plan
- Reset: hold `reset`=0 with random inputs → `out`=0, `overflow`=0, `done`=0, `in_ready`=0, `busy`=0. Release → still IDLE.
- Default params: start; beats 0xFF, 0x0F, 0x01 (last) on consecutive cycles → `done` for one cycle at edge N+1, `out`=13, `overflow`=0. `out` holds 13 after `done` falls.
- Zero-count mode: start with `count_zeros`=1; beats 0xFF, 0x00 (last) → `out`=8. Next packet with `count_zeros`=0, 0x00 (last) → `out`=0.
- Overflow: DATA_W=8, CNT_W=4.
  - SAT=1, three 0xFF → `out`=15, `overflow`=1.
  - SAT=0, same stimulus → `out`=8 (24 mod 16), `overflow`=1.
  - Following packet of a single 0x03 → `overflow`=0.
- Flow control: `in_valid` toggled with gaps, `start` pulsed during ACCUM, `in_valid`=1 in IDLE → gaps add nothing, mid-packet `start` has no effect, no beat is consumed while `in_ready`=0. Result equals the sum of accepted beats only.
- Abort: `reset` low after two beats of a packet → immediate zeroing, no `done`. A fresh packet 0xAA (last) → `out`=4.
